cnt_frame_rx: RTL and testbench

CNT_FRAME_RX -- requirements
Module: cnt_frame_rx

---
 rtl/cnt_frame_rx_if.sv | 22 ++
 rtl/cnt_frame_rx.sv | 120 ++++++++++++
 tb/tb_cnt_frame_rx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_frame_rx_if.sv
// cnt_frame_rx_if: word input and captured-frame output bundle for cnt_frame_rx.
// master = word source / frame consumer, slave = the receiver.
interface cnt_frame_rx_if;
  logic [9:0]       word_in;
  logic             word_strobe;
  logic             clr_frame;
  logic [52:0][9:0] words_out;
  logic             frame_valid;
  logic             frame_err;
  logic             overrun;
  logic [6:0]       word_cnt;

  modport master (
    output word_in, word_strobe, clr_frame,
    input  words_out, frame_valid, frame_err, overrun, word_cnt
  );

  modport slave (
    input  word_in, word_strobe, clr_frame,
    output words_out, frame_valid, frame_err, overrun, word_cnt
  );
endinterface

// File: rtl/cnt_frame_rx.sv
// cnt_frame_rx: hunts for header 10'h234, captures 53 data words, checks
// trailer 10'h0BF and holds the frame until clr_frame releases it.
// Optional macro CNT_RX_TIMEOUT_EN adds a 10-bit idle timeout in CAPTURE/TRAILER.
module cnt_frame_rx (
  input  logic           clk50,
  input  logic           rst_n,
  cnt_frame_rx_if.slave  bus
);
  localparam logic [9:0] HDR  = 10'h234;
  localparam logic [9:0] TRL  = 10'h0BF;
  localparam logic [6:0] LAST = 7'd52;

  typedef enum logic [1:0] {HUNT, CAPTURE, TRAILER, HOLD} state_e;

  state_e           state_q, state_d;
  logic [1:0]       strb_q, strb_d;
  logic [52:0][9:0] words_q, words_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             word_ev;
`ifdef CNT_RX_TIMEOUT_EN
  logic [9:0]       idle_q, idle_d;
`endif

  // Next-state: strobe edge detect, frame FSM, capture storage and flags
  always_comb begin
    strb_d  = {strb_q[0], bus.word_strobe};
    word_ev = (strb_q == 2'b01);
    state_d = state_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
`ifdef CNT_RX_TIMEOUT_EN
    idle_d  = '0;
`endif
    case (state_q)
      HUNT: begin
        if (word_ev && bus.word_in == HDR) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        // header/trailer codes mid-frame are plain data
        if (word_ev) begin
          words_d[cnt_q[5:0]] = bus.word_in;
          cnt_d               = cnt_q + 7'd1;
          if (cnt_q == LAST) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (word_ev) begin
          state_d = HOLD;
          if (bus.word_in == TRL) valid_d = 1'b1;
          else                    err_d   = 1'b1;
        end
      end
      HOLD: begin
        // clear beats a simultaneous word: the word is dropped silently
        if (bus.clr_frame) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = HUNT;
        end else if (word_ev) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
`ifdef CNT_RX_TIMEOUT_EN
    // idle clocks only accumulate while a frame is in flight
    if ((state_q == CAPTURE || state_q == TRAILER) && !word_ev) begin
      if (idle_q == 10'h3FF) begin
        state_d = HOLD;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + 10'd1;
      end
    end
`endif
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q <= HUNT;
      strb_q  <= 2'b00;
      words_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef CNT_RX_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
`ifdef CNT_RX_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign bus.words_out   = words_q;
  assign bus.word_cnt    = cnt_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_cnt_frame_rx.sv
// tb_cnt_frame_rx: directed + randomized frames against a behavioural frame model.
module tb_cnt_frame_rx;
  localparam logic [9:0] HDR = 10'h234;
  localparam logic [9:0] TRL = 10'h0BF;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  cnt_frame_rx_if bus();

  cnt_frame_rx dut (.clk50(clk50), .rst_n(rst_n), .bus(bus));

  always #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit rnd_clr = 1'b0;
  int vld_rises = 0;
  bit prev_vld = 1'b0;

  // behavioural model: phase 0 hunting, 1 collecting data, 2 awaiting trailer, 3 holding
  int         m_phase, m_cnt, m_idle;
  bit         m_valid, m_err, m_ovr, s1, s2, m_ev;
  logic [9:0] m_words [53];

  always @(posedge clk50) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_idle = 0;
      m_valid = 0; m_err = 0; m_ovr = 0; s1 = 0; s2 = 0;
      foreach (m_words[i]) m_words[i] = '0;
    end else begin
      m_ev = s1 && !s2;                 // strobe rose one sample ago
      s2 = s1;
      s1 = bus.word_strobe;
      case (m_phase)
        0: if (m_ev && bus.word_in == HDR) begin m_phase = 1; m_cnt = 0; m_idle = 0; end
        1, 2: begin
          if (m_ev) begin
            m_idle = 0;
            if (m_phase == 1) begin
              m_words[m_cnt] = bus.word_in;
              m_cnt++;
              if (m_cnt == 53) m_phase = 2;
            end else begin
              m_phase = 3;
              if (bus.word_in == TRL) m_valid = 1; else m_err = 1;
            end
          end else begin
`ifdef CNT_RX_TIMEOUT_EN
            if (m_idle == 1023) begin m_phase = 3; m_err = 1; m_idle = 0; end
            else m_idle++;
`endif
          end
        end
        default: begin
          if (bus.clr_frame) begin m_valid = 0; m_err = 0; m_ovr = 0; m_phase = 0; end
          else if (m_ev) m_ovr = 1;
        end
      endcase
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk50) begin
    if (chk_on) begin
      int bad_i;
      cmp("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
      cmp("frame_err", 32'(bus.frame_err), 32'(m_err));
      cmp("overrun", 32'(bus.overrun), 32'(m_ovr));
      cmp("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
      cmp("valid_err_excl", 32'(bus.frame_valid & bus.frame_err), 32'd0);
      bad_i = -1;
      for (int i = 52; i >= 0; i--) if (bus.words_out[i] !== m_words[i]) bad_i = i;
      n_cmp++;
      if (bad_i >= 0) begin
        n_bad++;
        $display("FAIL words_out[%0d]: got %0h expected %0h at %0t",
                 bad_i, bus.words_out[bad_i], m_words[bad_i], $time);
      end
      if (bus.frame_valid === 1'b1 && !prev_vld) vld_rises++;
      prev_vld = (bus.frame_valid === 1'b1);
    end
  end

  // present one word: strobe high two clocks, then gap low clocks;
  // race puts clr_frame on the same clock the word event is taken
  task automatic send(input logic [9:0] w, input int gap, input bit race);
    bus.clr_frame   = 1'b0;
    bus.word_in     = w;
    bus.word_strobe = 1'b1;
    @(negedge clk50);
    if (race) bus.clr_frame = 1'b1;
    @(negedge clk50);
    bus.clr_frame   = 1'b0;
    bus.word_strobe = 1'b0;
    repeat (gap) begin
      @(negedge clk50);
      bus.clr_frame = rnd_clr && ($urandom_range(0, 15) == 0);
    end
    bus.clr_frame = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_frame = 1'b1;
    @(negedge clk50);
    bus.clr_frame = 1'b0;
    @(negedge clk50);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
  endtask

  task automatic good_frame_idx3(input logic [9:0] trailer);
    send(HDR, 1, 0);
    for (int i = 0; i < 53; i++) send(10'(i * 3), 1, 0);
    send(trailer, 1, 0);
  endtask

  task automatic rnd_word(output logic [9:0] w);
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      w = HDR;
    else if (r == 1) w = TRL;
    else             w = 10'($urandom_range(0, 1023));
  endtask

  initial begin
    logic [9:0] w;
    bus.word_in = '0; bus.word_strobe = 1'b0; bus.clr_frame = 1'b0;
    rst_n = 1'b0;
    @(negedge clk50);
    chk_on = 1'b1;
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);

    // reset state
    cmp("rst_valid", 32'(bus.frame_valid), 32'd0);
    cmp("rst_cnt", 32'(bus.word_cnt), 32'd0);
    cmp("rst_w0", 32'(bus.words_out[0]), 32'd0);
    cmp("rst_w52", 32'(bus.words_out[52]), 32'd0);

    // garbage before header, then good frame with data = index*3
    vld_rises = 0;
    send(10'h111, 2, 0);
    send(TRL, 2, 0);
    cmp("garbage_cnt", 32'(bus.word_cnt), 32'd0);
    good_frame_idx3(TRL);
    cmp("good_valid", 32'(bus.frame_valid), 32'd1);
    cmp("good_err", 32'(bus.frame_err), 32'd0);
    cmp("good_cnt", 32'(bus.word_cnt), 32'd53);
    cmp("good_w0", 32'(bus.words_out[0]), 32'd0);
    cmp("good_w17", 32'(bus.words_out[17]), 32'd51);
    cmp("good_w52", 32'(bus.words_out[52]), 32'd156);
    cmp("one_valid", 32'(vld_rises), 32'd1);

    // clear coinciding with a word event: clear wins, no overrun
    send(10'h005, 2, 1);
    cmp("race_ovr", 32'(bus.overrun), 32'd0);
    cmp("race_valid", 32'(bus.frame_valid), 32'd0);

    // extra word in HOLD sets overrun and is discarded
    good_frame_idx3(TRL);
    send(10'h3AA, 2, 0);
    cmp("ovr_set", 32'(bus.overrun), 32'd1);
    cmp("ovr_w52", 32'(bus.words_out[52]), 32'd156);
    cmp("ovr_cnt", 32'(bus.word_cnt), 32'd53);
    pulse_clr();
    cmp("ovr_clr", 32'(bus.overrun), 32'd0);

    // bad trailer
    good_frame_idx3(10'h2BF);
    cmp("bad_err", 32'(bus.frame_err), 32'd1);
    cmp("bad_valid", 32'(bus.frame_valid), 32'd0);
    pulse_clr();
    cmp("bad_clr_err", 32'(bus.frame_err), 32'd0);
    cmp("bad_clr_valid", 32'(bus.frame_valid), 32'd0);

    // clr_frame outside HOLD: ignored mid-capture
    send(HDR, 1, 0);
    send(10'h077, 1, 0);
    pulse_clr();
    send(10'h078, 1, 0);
    cmp("clr_noeffect_cnt", 32'(bus.word_cnt), 32'd2);

    // reset mid-frame, then a good frame
    do_reset();
    cmp("rstmid_cnt", 32'(bus.word_cnt), 32'd0);
    cmp("rstmid_w0", 32'(bus.words_out[0]), 32'd0);
    send(HDR, 1, 0);
    for (int i = 0; i < 21; i++) send(10'(i + 100), 1, 0);
    do_reset();
    cmp("rstmid_err", 32'(bus.frame_err), 32'd0);
    good_frame_idx3(TRL);
    cmp("rstmid_valid", 32'(bus.frame_valid), 32'd1);
    cmp("rstmid_cnt53", 32'(bus.word_cnt), 32'd53);
    cmp("rstmid_noerr", 32'(bus.frame_err), 32'd0);
    pulse_clr();

    // idle after header + 10 words
    send(HDR, 1, 0);
    for (int i = 0; i < 10; i++) send(10'(i + 1), 1, 0);
    repeat (1100) @(negedge clk50);
    cmp("idle_cnt", 32'(bus.word_cnt), 32'd10);
`ifdef CNT_RX_TIMEOUT_EN
    cmp("idle_err", 32'(bus.frame_err), 32'd1);
`else
    cmp("idle_err", 32'(bus.frame_err), 32'd0);
`endif
    do_reset();

    // randomized frames
    rnd_clr = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int rst_at;
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 52)) : -1;
      repeat ($urandom_range(0, 2)) begin
        w = 10'($urandom_range(0, 1023));
        if (w == HDR) w = 10'h111;
        send(w, $urandom_range(1, 3), 0);
      end
      send(HDR, $urandom_range(1, 3), 0);
      for (int i = 0; i < 53; i++) begin
        if (i == rst_at) do_reset();
        rnd_word(w);
        send(w, $urandom_range(1, 3), 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        w = 10'($urandom_range(0, 1023));
        if (w == TRL) w = 10'h2BF;
      end else w = TRL;
      send(w, $urandom_range(1, 3), 0);
      repeat ($urandom_range(0, 2)) send(10'($urandom_range(0, 1023)), $urandom_range(1, 3), 0);
      if ($urandom_range(0, 1) == 1) send(10'($urandom_range(0, 1023)), 2, 1);
      else pulse_clr();
    end

    repeat (4) @(negedge clk50);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
